// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback arbiter for the RegFile write port, with an X0..X30 clear sweep
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_reg,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_reg,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  write,
  output logic [ADDR_WIDTH-1:0] writeReg,
  output logic [DATA_WIDTH-1:0] writeData
);
  localparam logic [ADDR_WIDTH-1:0] ZR   = ADDR_WIDTH'(ZERO_REG);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(ZERO_REG - 1);
  typedef enum logic {ARB, CLEAR} state_t;
  state_t state, state_next;
  logic   ptr;
  logic   take0, take1;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ARB;
    else     state <= state_next;
  always_comb
    state_next = (state == ARB) ? (clear_req ? CLEAR : ARB) : (writeReg == LAST ? ARB : CLEAR);
  always_comb begin
    clear_busy = (state == CLEAR);
    req0_ready = (state == ARB) && !clear_req && (!req1_valid || !ptr);
    req1_ready = (state == ARB) && !clear_req && (!req0_valid || ptr);
  end
  assign take0 = req0_valid && req0_ready;
  assign take1 = req1_valid && req1_ready;
  // Writes to the zero register are accepted but never reach the RegFile.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr       <= 1'b0;
      write     <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else if (state == CLEAR) begin
      write    <= (writeReg != LAST);
      writeReg <= (writeReg == LAST) ? writeReg : writeReg + 1'b1;
    end else if (clear_req) begin
      write     <= 1'b1;
      writeReg  <= '0;
      writeData <= '0;
    end else if (take0) begin
      write     <= (req0_reg != ZR);
      writeReg  <= req0_reg;
      writeData <= req0_data;
      ptr       <= 1'b1;
    end else if (take1) begin
      write     <= (req1_reg != ZR);
      writeReg  <= req1_reg;
      writeData <= req1_data;
      ptr       <= 1'b0;
    end else
      write <= 1'b0;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random checks of the writeback arbiter against a behavioural model
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, clear_req = 1'b0;
  logic        req0_ready, req1_ready, clear_busy, write;
  logic [4:0]  req0_reg = '0, req1_reg = '0, writeReg;
  logic [63:0] req0_data = '0, req1_data = '0, writeData;
  int          vectors = 0;
  int          miscompares = 0;
  // Model: sweep as a count of remaining writes, arbitration as "whose turn it is".
  bit          m_sweep;
  int          m_left;
  int          m_turn;
  bit          m_write;
  logic [4:0]  m_reg;
  logic [63:0] m_data;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_reg(req0_reg), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_reg(req1_reg), .req1_data(req1_data),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .write(write), .writeReg(writeReg), .writeData(writeData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sweep = 0; m_left = 0; m_turn = 0; m_write = 0; m_reg = '0; m_data = '0;
  endtask

  task automatic step(input bit v0, input logic [4:0] g0, input logic [63:0] d0,
                      input bit v1, input logic [4:0] g1, input logic [63:0] d1, input bit clr);
    bit e0, e1, busy;
    req0_valid = v0; req0_reg = g0; req0_data = d0;
    req1_valid = v1; req1_reg = g1; req1_data = d1;
    clear_req = clr;
    #1;
    busy = m_sweep || clr;
    e0 = !busy && (!v1 || m_turn == 0);
    e1 = !busy && (!v0 || m_turn == 1);
    chk("req0_ready", {63'd0, req0_ready}, {63'd0, e0});
    chk("req1_ready", {63'd0, req1_ready}, {63'd0, e1});
    if (m_sweep) begin
      m_left--;
      if (m_left == 0) begin m_sweep = 0; m_write = 0; end
      else begin m_reg = m_reg + 5'd1; m_write = 1; end
    end else if (clr) begin
      m_sweep = 1; m_left = 31; m_write = 1; m_reg = '0; m_data = '0;
    end else if (v0 && e0) begin
      m_write = (g0 != 5'd31); m_reg = g0; m_data = d0; m_turn = 1;
    end else if (v1 && e1) begin
      m_write = (g1 != 5'd31); m_reg = g1; m_data = d1; m_turn = 0;
    end else
      m_write = 0;
    @(posedge clk); #1;
    chk("write", {63'd0, write}, {63'd0, m_write});
    chk("writeReg", {59'd0, writeReg}, {59'd0, m_reg});
    chk("writeData", writeData, m_data);
    chk("clear_busy", {63'd0, clear_busy}, {63'd0, m_sweep});
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; clear_req = 0;
    #1;
    model_reset();
    chk("rst_write", {63'd0, write}, 64'd0);
    chk("rst_writeReg", {59'd0, writeReg}, 64'd0);
    chk("rst_writeData", writeData, 64'd0);
    chk("rst_clear_busy", {63'd0, clear_busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #12;
    do_reset();
    step(1, 5'd2, 64'd3, 0, '0, '0, 0);
    step(0, '0, '0, 1, 5'd31, 64'hDEAD, 0);
    step(0, '0, '0, 0, '0, '0, 0);
    do_reset();
    repeat (4) step(1, 5'd5, 64'd4, 1, 5'd1, 64'd10, 0);
    step(1, 5'd7, 64'd9, 0, '0, '0, 1);
    for (int i = 0; i < 31; i++) step(1, 5'd7, 64'd9, 0, '0, '0, i == 10);
    step(1, 5'd7, 64'd9, 0, '0, '0, 0);
    step(0, '0, '0, 0, '0, '0, 1);
    for (int i = 0; i < 12; i++) step(0, '0, '0, 1, 5'd3, 64'd1, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_write", {63'd0, write}, 64'd0);
    chk("async_writeReg", {59'd0, writeReg}, 64'd0);
    chk("async_clear_busy", {63'd0, clear_busy}, 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1, 5'd8, 64'd11, 1, 5'd9, 64'd12, 0);
    step(1, 5'd8, 64'd11, 1, 5'd9, 64'd12, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), 5'($urandom_range(0, 31)), {$urandom, $urandom},
           $urandom_range(0, 1), 5'($urandom_range(0, 31)), {$urandom, $urandom},
           $urandom_range(0, 39) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
